boa_extmem_sram_wide: RTL and testbench

//  Parametrised successor to the byte-wide external SRAM controller. Bridges one 32-bit
//  boa_mem_bus slave port (extram region of main) to an external asynchronous-style SRAM
//  of 8/16/32-bit data width, with programmable wait states, read latency and byte

---
 rtl/boa_extmem_sram_wide_pkg.sv | 22 ++
 rtl/boa_extmem_sram_wide_if.sv | 16 +
 rtl/boa_extmem_sram_wide.sv | 154 +++++++++++++++
 tb/tb_boa_extmem_sram_wide.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boa_extmem_sram_wide_pkg.sv
// Shared types and helpers for the wide external SRAM controller.
// Holds the FSM state encoding and the write-beat skipping search.
package boa_extmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    LAT  = 2'd2,
    DONE = 2'd3
  } state_e;

  // First beat >= from that owns at least one enabled byte lane; beats means none left.
  function automatic int next_beat(logic [3:0] we, int from, int beats);
    int lpb;
    lpb = 4 / beats;
    next_beat = beats;
    for (int i = 3; i >= 0; i--) begin
      if (we[i] && ((i / lpb) >= from)) next_beat = i / lpb;
    end
  endfunction

endpackage

// File: rtl/boa_extmem_sram_wide_if.sv
// 32-bit memory bus between the core and a memory-mapped region controller.
// Handshake: the master holds re or a nonzero we (with addr/wdata) until it samples
// ready=1 in the same cycle; that cycle completes the transfer and rdata is valid then.
interface boa_mem_bus #(
  parameter int alen = 19
);
  logic            re;
  logic [3:0]      we;
  logic [alen-1:0] addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            ready;

  modport master (output re, we, addr, wdata, input rdata, ready);
  modport slave  (input re, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/boa_extmem_sram_wide.sv
// Bridges a 32-bit boa_mem_bus slave to an 8/16/32-bit asynchronous SRAM, splitting each
// access into sequential beats with programmable strobe width and read latency.
module boa_extmem_sram_wide
  import boa_extmem_pkg::*;
#(
  parameter int alen   = 19,
  parameter int dw     = 8,
  parameter int waits  = 0,
  parameter int rd_lat = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  boa_mem_bus.slave                       bus,
  output logic                            sram_re,
  output logic                            sram_we,
  output logic [dw/8-1:0]                 sram_be,
  output logic [alen-$clog2(dw/8)-1:0]    sram_addr,
  output logic [dw-1:0]                   sram_wdata,
  input  logic [dw-1:0]                   sram_rdata,
  output state_e                          dbg_state
);

  localparam int BEATS = 32 / dw;
  localparam int LANES = dw / 8;
  localparam int SAW   = alen - $clog2(LANES);
  localparam int MAXC  = ((waits + 1) > rd_lat) ? (waits + 1) : rd_lat;
  localparam int CW    = $clog2(MAXC + 1);

  if (dw != 8 && dw != 16 && dw != 32) begin : g_bad_dw
    $error("boa_extmem_sram_wide: dw must be 8, 16 or 32");
  end

  state_e           state;
  logic [2:0]       beat_q;
  logic [CW-1:0]    cnt;
  logic             write_q;
  logic [3:0]       we_q;
  logic [31:0]      wdata_q;
  logic [alen-3:0]  word_q;
  logic [31:0]      rdata_q;

  logic             req;
  logic             src_write;
  logic [3:0]       src_we;
  logic [31:0]      src_wdata;
  logic [alen-3:0]  src_word;
  int               from_beat;
  int               nb;
  int               nb_idx;
  logic [LANES-1:0] ld_be;
  logic [dw-1:0]    ld_wdata;
  logic [SAW-1:0]   ld_addr;

  // The next beat is computed from the live bus in IDLE and from the latched copy afterwards.
  always_comb begin
    req       = bus.re || (bus.we != 4'd0);
    src_write = write_q;
    src_we    = we_q;
    src_wdata = wdata_q;
    src_word  = word_q;
    from_beat = int'(beat_q) + 1;
    if (state == IDLE) begin
      src_write = (bus.we != 4'd0);
      src_we    = bus.we;
      src_wdata = bus.wdata;
      src_word  = bus.addr[alen-1:2];
      from_beat = 0;
    end
    nb       = src_write ? next_beat(src_we, from_beat, BEATS) : from_beat;
    nb_idx   = (nb < BEATS) ? nb : 0;
    ld_be    = src_we[nb_idx*LANES +: LANES];
    ld_wdata = src_wdata[nb_idx*dw +: dw];
    ld_addr  = SAW'({src_word, 2'b00} >> $clog2(LANES)) | SAW'(nb_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat_q     <= '0;
      cnt        <= '0;
      write_q    <= 1'b0;
      we_q       <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      rdata_q    <= '0;
      sram_re    <= 1'b0;
      sram_we    <= 1'b0;
      sram_be    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            write_q    <= src_write;
            we_q       <= bus.we;
            wdata_q    <= bus.wdata;
            word_q     <= bus.addr[alen-1:2];
            beat_q     <= 3'(nb_idx);
            cnt        <= '0;
            sram_re    <= !src_write;
            sram_we    <= src_write;
            sram_be    <= ld_be;
            sram_addr  <= ld_addr;
            sram_wdata <= ld_wdata;
            state      <= BEAT;
          end
        end
        BEAT: begin
          if (cnt == CW'(waits)) begin
            cnt <= '0;
            if (!write_q) begin
              sram_re <= 1'b0;
              state   <= LAT;
            end else if (nb < BEATS) begin
              beat_q     <= 3'(nb_idx);
              sram_be    <= ld_be;
              sram_addr  <= ld_addr;
              sram_wdata <= ld_wdata;
            end else begin
              sram_we <= 1'b0;
              sram_be <= '0;
              state   <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LAT: begin
          if (cnt == CW'(rd_lat - 1)) begin
            cnt <= '0;
            rdata_q[int'(beat_q)*dw +: dw] <= sram_rdata;
            if (nb < BEATS) begin
              beat_q    <= 3'(nb_idx);
              sram_re   <= 1'b1;
              sram_addr <= ld_addr;
              state     <= BEAT;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = !rst && (((state == IDLE) && !req) || (state == DONE));
  assign bus.rdata = rdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_boa_extmem_sram_wide.sv
// Bench for boa_extmem_sram_wide: three controllers (dw 8/16/32) each on a byte-lane SRAM
// model with one cycle read latency; directed transfers scored against an expected queue.
module tb_boa_extmem_sram_wide;
  import boa_extmem_pkg::*;

  localparam int AL = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]          re_a;
  logic [2:0][3:0]     we_a;
  logic [2:0][AL-1:0]  addr_a;
  logic [2:0][31:0]    wdata_a;
  logic [2:0][31:0]    rdata_a;
  logic [2:0]          ready_a;
  logic [2:0]          sre_a;
  logic [2:0]          swe_a;
  logic [2:0][AL-1:0]  saddr_a;
  logic [2:0][1:0]     st_a;
  logic [2:0][3:0]     sbe_a;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GDW  = (g == 0) ? 8 : ((g == 1) ? 16 : 32);
    localparam int GW   = (g == 1) ? 2 : 0;
    localparam int GL   = GDW / 8;
    localparam int GSAW = AL - $clog2(GL);

    boa_mem_bus #(.alen(AL)) bus ();
    logic            sram_re;
    logic            sram_we;
    logic [GL-1:0]   sram_be;
    logic [GSAW-1:0] sram_addr;
    logic [GDW-1:0]  sram_wdata;
    logic [GDW-1:0]  sram_rdata;
    state_e          dbg_state;
    logic [7:0]      mem [1<<AL];

    initial begin
      for (int i = 0; i < (1 << AL); i++) mem[i] = 8'h00;
      sram_rdata = '0;
    end

    assign bus.re     = re_a[g];
    assign bus.we     = we_a[g];
    assign bus.addr   = addr_a[g];
    assign bus.wdata  = wdata_a[g];
    assign rdata_a[g] = bus.rdata;
    assign ready_a[g] = bus.ready;
    assign sre_a[g]   = sram_re;
    assign swe_a[g]   = sram_we;
    assign saddr_a[g] = AL'(sram_addr);
    assign st_a[g]    = dbg_state;
    assign sbe_a[g]   = 4'(sram_be);

    boa_extmem_sram_wide #(.alen(AL), .dw(GDW), .waits(GW), .rd_lat(1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_re    (sram_re),
      .sram_we    (sram_we),
      .sram_be    (sram_be),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .dbg_state  (dbg_state)
    );

    always @(posedge clk) begin
      if (sram_we)
        for (int l = 0; l < GL; l++)
          if (sram_be[l]) mem[int'(sram_addr)*GL + l] <= sram_wdata[l*8 +: 8];
      if (sram_re)
        for (int l = 0; l < GL; l++) sram_rdata[l*8 +: 8] <= mem[int'(sram_addr)*GL + l];
      else
        sram_rdata <= {GL{8'hC3}};
    end
  end

  int          tests = 0;
  int          fails = 0;
  int          overlap = 0;
  int          done_cnt = 0;
  int          cyc [3];
  logic [2:0]  active = 3'b000;
  string       cur_name = "none";
  logic [42:0] exp_q[$];   // {inst[1:0], check_rdata, latency[7:0], rdata[31:0]}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int waits_of(int g);
    return (g == 1) ? 2 : 0;
  endfunction

  // Monitor: completion is the first ready seen while a request is outstanding.
  int          run_len [3] = '{0, 0, 0};
  logic [13:0] run_key [3];
  always @(negedge clk) begin
    logic [42:0] e;
    logic [13:0] key;
    for (int g = 0; g < 3; g++) begin
      if (sre_a[g] && swe_a[g]) overlap++;
      if (active[g]) begin
        if (ready_a[g]) begin
          if (exp_q.size() == 0) begin
            check({cur_name, "_unexpected_ready"}, 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check({cur_name, "_inst"}, 32'(g), 32'(e[42:41]));
            check({cur_name, "_latency"}, 32'(cyc[g]), 32'(e[39:32]));
            if (e[40]) check({cur_name, "_rdata"}, rdata_a[g], e[31:0]);
          end
          active[g] = 1'b0;
          done_cnt++;
        end else begin
          cyc[g]++;
        end
      end
      key = {sre_a[g], swe_a[g], saddr_a[g]};
      if (run_len[g] != 0 && key != run_key[g]) begin
        check($sformatf("strobe_hold_%0d", g), 32'(run_len[g]), 32'(waits_of(g) + 1));
        run_len[g] = 0;
      end
      if (sre_a[g] || swe_a[g]) begin
        run_key[g] = key;
        run_len[g]++;
      end
    end
  end

  // Called #1 after a rising edge; that cycle is cycle 0 of the transfer.
  task automatic do_req(input int g, input string name, input logic re, input logic [3:0] we,
                        input logic [AL-1:0] addr, input logic [31:0] wdata,
                        input logic chk, input int lat, input logic [31:0] exp_rd);
    int start_done;
    int waited;
    start_done = done_cnt;
    waited     = 0;
    re_a[g]    = re;
    we_a[g]    = we;
    addr_a[g]  = addr;
    wdata_a[g] = wdata;
    cur_name   = name;
    exp_q.push_back({2'(g), chk, 8'(lat), exp_rd});
    cyc[g]     = 0;
    active[g]  = 1'b1;
    while (done_cnt == start_done && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (done_cnt == start_done) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      active[g] = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    re_a[g] = 1'b0;
    we_a[g] = 4'h0;
  endtask

  initial begin
    re_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_ready_%0d", g), 32'(ready_a[g]), 32'd0);
      check($sformatf("rst_strobes_%0d", g), 32'({sre_a[g], swe_a[g]}), 32'd0);
      check($sformatf("rst_rdata_%0d", g), rdata_a[g], 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("idle_ready", 32'(ready_a), 32'h7);

    // dw=8, waits=0
    do_req(0, "w8_full",   1'b0, 4'hF,    12'h100, 32'hDEADBEEF, 1'b0, 5, 32'h0);
    check("w8_full_bytes", {g_dut[0].mem[12'h103], g_dut[0].mem[12'h102],
                            g_dut[0].mem[12'h101], g_dut[0].mem[12'h100]}, 32'hDEADBEEF);
    do_req(0, "r8_full",   1'b1, 4'h0,    12'h100, 32'h0,        1'b1, 9, 32'hDEADBEEF);
    do_req(0, "w8_lane2",  1'b0, 4'b0100, 12'h100, 32'h00AA0000, 1'b0, 2, 32'h0);
    do_req(0, "r8_lane2",  1'b1, 4'h0,    12'h100, 32'h0,        1'b1, 9, 32'hDEAABEEF);
    do_req(0, "rw8_both",  1'b1, 4'b0011, 12'h100, 32'h00001234, 1'b1, 3, 32'hDEAABEEF);
    do_req(0, "r8_both",   1'b1, 4'h0,    12'h100, 32'h0,        1'b1, 9, 32'hDEAA1234);
    do_req(0, "w8_sparse", 1'b0, 4'b1010, 12'h104, 32'h77556600, 1'b0, 3, 32'h0);
    do_req(0, "r8_sparse", 1'b1, 4'h0,    12'h104, 32'h0,        1'b1, 9, 32'h77006600);

    // dw=16, waits=2
    do_req(1, "w16_full",  1'b0, 4'hF,    12'h040, 32'h12345678, 1'b0, 7, 32'h0);
    check("w16_full_bytes", {g_dut[1].mem[12'h043], g_dut[1].mem[12'h042],
                             g_dut[1].mem[12'h041], g_dut[1].mem[12'h040]}, 32'h12345678);
    do_req(1, "r16_full",  1'b1, 4'h0,    12'h040, 32'h0,        1'b1, 9, 32'h12345678);
    do_req(1, "w16_hi",    1'b0, 4'b1100, 12'h040, 32'hABCD0000, 1'b0, 4, 32'h0);
    check("w16_hi_bytes", {g_dut[1].mem[12'h043], g_dut[1].mem[12'h042],
                           g_dut[1].mem[12'h041], g_dut[1].mem[12'h040]}, 32'hABCD5678);
    do_req(1, "r16_hi",    1'b1, 4'h0,    12'h040, 32'h0,        1'b1, 9, 32'hABCD5678);

    // dw=32, waits=0, back-to-back
    do_req(2, "w32_full",  1'b0, 4'hF,    12'h080, 32'hCAFEF00D, 1'b0, 2, 32'h0);
    do_req(2, "r32_full",  1'b1, 4'h0,    12'h080, 32'h0,        1'b1, 3, 32'hCAFEF00D);
    do_req(2, "w32_lane0", 1'b0, 4'b0001, 12'h080, 32'h000000EE, 1'b0, 2, 32'h0);
    do_req(2, "r32_lane0", 1'b1, 4'h0,    12'h080, 32'h0,        1'b1, 3, 32'hCAFEF0EE);

    // Reset during beat 2 of a dw=8 write
    do_req(0, "w8_pre",    1'b0, 4'hF,    12'h200, 32'hA5A5A5A5, 1'b0, 5, 32'h0);
    cur_name   = "abort";
    we_a[0]    = 4'hF;
    addr_a[0]  = 12'h200;
    wdata_a[0] = 32'h11223344;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_strobes", 32'({sre_a[0], swe_a[0]}), 32'd0);
    check("abort_be", 32'(sbe_a[0]), 32'd0);
    check("abort_ready", 32'(ready_a[0]), 32'd0);
    check("abort_state", 32'(st_a[0]), 32'(IDLE));
    @(posedge clk);
    #1;
    we_a[0] = 4'h0;
    rst     = 1'b0;
    #1;
    check("post_rst_ready", 32'(ready_a[0]), 32'd1);
    check("abort_bytes", {g_dut[0].mem[12'h203], g_dut[0].mem[12'h202],
                          g_dut[0].mem[12'h201], g_dut[0].mem[12'h200]}, 32'hA5A53344);
    @(posedge clk);
    #1;
    do_req(0, "r8_abort",  1'b1, 4'h0,    12'h200, 32'h0,        1'b1, 9, 32'hA5A53344);

    repeat (2) @(posedge clk);
    #1;
    check("re_we_overlap", 32'(overlap), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
